// File: rtl/frame_rsp_pkg.sv
// Shared types and field constants for the frame response checker.
// Record layout, FSM states, error bit positions and frame-ID field slices.
package frame_rsp_pkg;

  localparam int FR_ID_W  = 32;
  localparam int FR_OFS_W = 5;
  localparam int FR_LEN_W = FR_OFS_W + 1;
  localparam logic [FR_LEN_W-1:0] FR_LEN_MAX = FR_LEN_W'(1 << FR_OFS_W);
  localparam logic [FR_LEN_W-1:0] FR_LEN_SAT = FR_LEN_W'((1 << FR_OFS_W) + 1);

  localparam int ERR_NO_SOP   = 0;
  localparam int ERR_SOP_IN   = 1;
  localparam int ERR_OVERLONG = 2;
  localparam int ERR_SEQ      = 3;

  localparam int PORT_MSB = 31;
  localparam int PORT_LSB = 28;
  localparam int SEQ_MSB  = 27;
  localparam int SEQ_LSB  = 0;
  localparam int SEQ_W    = SEQ_MSB - SEQ_LSB + 1;

  typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} frame_rsp_state_t;

  typedef struct packed {
    logic [FR_ID_W-1:0]  frame_id;
    logic [FR_LEN_W-1:0] len;
    logic [3:0]          err;
  } frame_rsp_rec_t;

  function automatic logic [3:0] err_bit(input int idx);
    return 4'(1) << idx;
  endfunction

endpackage

// File: rtl/frame_rsp_fifo.sv
// Result-record FIFO, first-word-fall-through, two write lanes (lane 1 only with lane 0).
// Latency: a push is visible on rd_dat/rd_vld the cycle after; caller keeps >=2 entries free before pushing.
module frame_rsp_fifo
  import frame_rsp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push0,
  input  frame_rsp_rec_t wr_dat0,
  input  logic           push1,
  input  frame_rsp_rec_t wr_dat1,
  input  logic           pop,
  output frame_rsp_rec_t rd_dat,
  output logic           rd_vld,
  output logic [CW-1:0]  count
);

  localparam int AW = $clog2(DEPTH);

  frame_rsp_rec_t  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop_ok;

  assign rd_vld = (count != '0);
  assign pop_ok = pop && rd_vld;
  assign rd_dat = mem[rd_ptr];

  // Storage is reset so the result outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push0) mem[wr_ptr] <= wr_dat0;
      if (push1) mem[wr_ptr + AW'(1)] <= wr_dat1;
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/frame_rsp_checker.sv
// Frame checker: framing/ID/length (+ per-port sequence with FRAME_RSP_SEQ_CHECK_EN), one record per frame.
// Latency 1 cycle from closing beat to res_*; noc_ready_out is registered "result FIFO has >=2 free entries".
module frame_rsp_checker
  import frame_rsp_pkg::*;
#(
  parameter int AVL_DATA_WIDTH     = 518,
  parameter int FRAME_ID_WIDTH     = 32,
  parameter int FRAME_OFFSET_WIDTH = 5,
  parameter int WIDTH_PKT          = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH,
  parameter int RES_FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH_PKT-1:0]          noc_data_in,
  input  logic [3:0]                    noc_valid_in,
  input  logic [3:0]                    noc_sop_in,
  input  logic [3:0]                    noc_eop_in,
  output logic                          noc_ready_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [FRAME_ID_WIDTH-1:0]     res_frame_id,
  output logic [FRAME_OFFSET_WIDTH:0]   res_len,
  output logic [3:0]                    res_err,
  output logic [15:0]                   frame_cnt,
  output logic [15:0]                   err_cnt
);

  localparam int CW = $clog2(RES_FIFO_DEPTH) + 1;

  frame_rsp_state_t    state;
  logic [FR_ID_W-1:0]  cur_id;
  logic [FR_ID_W-1:0]  beat_id;
  logic [FR_LEN_W-1:0] cur_len;
  logic [FR_LEN_W-1:0] len_inc;
  logic [3:0]          cur_err;
  logic [3:0]          err_ovl;
  logic [3:0]          err_mism;
  logic [3:0]          err_open;
  logic                sop;
  logic                eop;
  logic                acc;
  logic                pop;
  logic                seq_err;
  logic                push0;
  logic                push1;
  frame_rsp_rec_t      rec0;
  frame_rsp_rec_t      rec1;
  frame_rsp_rec_t      rd_rec;
  logic [CW-1:0]       fifo_cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [1:0]          n_ok;
  logic [1:0]          n_bad;
  logic                unused_bits;

  assign beat_id     = noc_data_in[WIDTH_PKT-1 -: FRAME_ID_WIDTH];
  assign unused_bits = ^noc_data_in[AVL_DATA_WIDTH+1:0];

  always_comb begin
    sop      = |noc_sop_in;
    eop      = |noc_eop_in;
    acc      = (|noc_valid_in) && noc_ready_out;
    pop      = res_valid && res_ready;
    len_inc  = (cur_len == FR_LEN_SAT) ? FR_LEN_SAT : cur_len + 1'b1;
    err_ovl  = (len_inc > FR_LEN_MAX) ? err_bit(ERR_OVERLONG) : 4'b0;
    err_mism = (beat_id != cur_id) ? err_bit(ERR_SOP_IN) : 4'b0;
    err_open = seq_err ? err_bit(ERR_SEQ) : 4'b0;
    push0    = 1'b0;
    push1    = 1'b0;
    rec0     = '0;
    rec1     = '0;
    if (acc) begin
      case (state)
        IDLE: if (eop) begin
          push0 = 1'b1;
          rec0  = '{frame_id: beat_id, len: FR_LEN_W'(1),
                    err: sop ? err_open : err_bit(ERR_NO_SOP)};
        end
        // A SOP mid-frame closes the old frame on lane 0 and may close a 1-beat frame on lane 1.
        IN_FRAME: if (sop) begin
          push0 = 1'b1;
          rec0  = '{frame_id: cur_id, len: cur_len, err: cur_err | err_bit(ERR_SOP_IN)};
          if (eop) begin
            push1 = 1'b1;
            rec1  = '{frame_id: beat_id, len: FR_LEN_W'(1), err: err_open};
          end
        end else if (eop) begin
          push0 = 1'b1;
          rec0  = '{frame_id: cur_id, len: len_inc, err: cur_err | err_mism | err_ovl};
        end
        DROP: if (eop) begin
          push0 = 1'b1;
          rec0  = '{frame_id: cur_id, len: len_inc, err: cur_err | err_ovl};
        end
        default: ;
      endcase
    end
    n_ok    = {1'b0, push0 && (rec0.err == 4'b0)} + {1'b0, push1 && (rec1.err == 4'b0)};
    n_bad   = {1'b0, push0 && (rec0.err != 4'b0)} + {1'b0, push1 && (rec1.err != 4'b0)};
    cnt_nxt = fifo_cnt + CW'(push0) + CW'(push1) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cur_id        <= '0;
      cur_len       <= '0;
      cur_err       <= '0;
      noc_ready_out <= 1'b0;
      frame_cnt     <= '0;
      err_cnt       <= '0;
    end else begin
      noc_ready_out <= (cnt_nxt <= CW'(RES_FIFO_DEPTH - 2));
      frame_cnt     <= frame_cnt + 16'(n_ok);
      err_cnt       <= err_cnt + 16'(n_bad);
      if (acc) begin
        case (state)
          IDLE: begin
            cur_id  <= beat_id;
            cur_len <= FR_LEN_W'(1);
            cur_err <= sop ? err_open : err_bit(ERR_NO_SOP);
            state   <= eop ? IDLE : (sop ? IN_FRAME : DROP);
          end
          IN_FRAME: if (sop) begin
            cur_id  <= beat_id;
            cur_len <= FR_LEN_W'(1);
            cur_err <= err_open;
            state   <= eop ? IDLE : IN_FRAME;
          end else begin
            cur_len <= len_inc;
            cur_err <= cur_err | err_mism | err_ovl;
            if (eop) state <= IDLE;
          end
          DROP: begin
            cur_len <= len_inc;
            cur_err <= cur_err | err_ovl;
            if (eop) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FRAME_RSP_SEQ_CHECK_EN
  logic [15:0]      seq_seen;
  logic [SEQ_W-1:0] seq_exp [16];
  logic [3:0]       port;
  logic [SEQ_W-1:0] seq;
  logic             opening;

  assign port    = beat_id[PORT_MSB:PORT_LSB];
  assign seq     = beat_id[SEQ_MSB:SEQ_LSB];
  assign seq_err = seq_seen[port] && (seq_exp[port] != seq);
  assign opening = acc && sop && (state != DROP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_seen <= '0;
      for (int i = 0; i < 16; i++) seq_exp[i] <= '0;
    end else if (opening) begin
      seq_seen[port] <= 1'b1;
      seq_exp[port]  <= seq + 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  frame_rsp_fifo #(
    .DEPTH (RES_FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push0   (push0),
    .wr_dat0 (rec0),
    .push1   (push1),
    .wr_dat1 (rec1),
    .pop     (pop),
    .rd_dat  (rd_rec),
    .rd_vld  (res_valid),
    .count   (fifo_cnt)
  );

  assign res_frame_id = rd_rec.frame_id;
  assign res_len      = rd_rec.len;
  assign res_err      = rd_rec.err;

endmodule

// File: tb/tb_frame_rsp_checker.sv
// Directed bench for frame_rsp_checker: framing, length, ID, backpressure and reset cases.
module tb_frame_rsp_checker;

  localparam int AW = 518;
  localparam int IW = 32;
  localparam int WP = AW + 2 + IW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WP-1:0] noc_data_in = '0;
  logic [3:0]    noc_valid_in = '0;
  logic [3:0]    noc_sop_in = '0;
  logic [3:0]    noc_eop_in = '0;
  logic          noc_ready_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_frame_id;
  logic [5:0]    res_len;
  logic [3:0]    res_err;
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;

  int total = 0;
  int bad = 0;
  int exp_ok = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  frame_rsp_checker dut (
    .clk           (clk),
    .rst           (rst),
    .noc_data_in   (noc_data_in),
    .noc_valid_in  (noc_valid_in),
    .noc_sop_in    (noc_sop_in),
    .noc_eop_in    (noc_eop_in),
    .noc_ready_out (noc_ready_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_frame_id  (res_frame_id),
    .res_len       (res_len),
    .res_err       (res_err),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one beat once the DUT is ready; returns 1 time unit after the accepting edge.
  task automatic beat(input logic [31:0] id, input logic s, input logic e);
    int n = 0;
    @(negedge clk);
    while (!noc_ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("beat_ready_timeout", 32'(noc_ready_out), 32'd1);
    noc_data_in = '0;
    noc_data_in[AW-1:0] = {$urandom, $urandom};
    noc_data_in[AW] = s;
    noc_data_in[AW+1] = e;
    noc_data_in[WP-1 -: IW] = id;
    noc_valid_in = 4'b0001;
    noc_sop_in = {3'b000, s};
    noc_eop_in = {3'b000, e};
    @(posedge clk);
    #1;
    noc_valid_in = '0;
    noc_sop_in = '0;
    noc_eop_in = '0;
  endtask

  task automatic frame(input logic [31:0] id, input int n);
    for (int i = 0; i < n; i++) beat(id, i == 0, i == n - 1);
  endtask

  task automatic chk_rec(input string tag, input logic [31:0] id, input logic [5:0] len,
                         input logic [3:0] err, input bit use_id, input bit use_len);
    int n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 32'(res_valid), 32'd1);
    if (use_id) chk({tag, "_id"}, res_frame_id, id);
    if (use_len) chk({tag, "_len"}, 32'(res_len), 32'(len));
    chk({tag, "_err"}, 32'(res_err), 32'(err));
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_ok));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(noc_ready_out), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_id", res_frame_id, 32'd0);
    chk("rst_len", 32'(res_len), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    chk_cnts("rst");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", 32'(noc_ready_out), 32'd1);

    // Single-beat frame, also checks 1-cycle latency
    beat(32'h3000_0005, 1'b1, 1'b1);
    chk("single_latency", 32'(res_valid), 32'd1);
    chk_rec("single", 32'h3000_0005, 6'd1, 4'b0000, 1'b1, 1'b1);
    exp_ok++;
    chk_cnts("single");

    // Two normal 4-beat frames
    frame(32'h1000_0000, 4);
    chk_rec("norm0", 32'h1000_0000, 6'd4, 4'b0000, 1'b1, 1'b1);
    frame(32'h1000_0001, 4);
    chk_rec("norm1", 32'h1000_0001, 6'd4, 4'b0000, 1'b1, 1'b1);
    exp_ok += 2;
    chk_cnts("norm");
`ifdef FRAME_RSP_SEQ_CHECK_EN
    frame(32'h1000_0003, 4);
    chk_rec("seqgap", 32'h1000_0003, 6'd4, 4'b1000, 1'b1, 1'b1);
    exp_err++;
    chk_cnts("seqgap");
`endif

    // Missing SOP
    beat(32'h2000_0000, 1'b0, 1'b0);
    beat(32'h2000_0000, 1'b0, 1'b1);
    chk_rec("nosop", 32'h2000_0000, 6'd2, 4'b0001, 1'b0, 1'b1);
    exp_err++;
    chk_cnts("nosop");

    // Overlong: 33 beats
    frame(32'h4000_0000, 33);
    chk_rec("ovl", 32'h4000_0000, 6'd33, 4'b0100, 1'b1, 1'b1);
    exp_err++;
    chk_cnts("ovl");

    // Backpressure: three records held with res_ready low
    beat(32'h5000_0000, 1'b1, 1'b1);
    beat(32'h5000_0001, 1'b1, 1'b1);
    chk("bp_ready_2", 32'(noc_ready_out), 32'd1);
    beat(32'h5000_0002, 1'b1, 1'b1);
    chk("bp_ready_3", 32'(noc_ready_out), 32'd0);
    chk_rec("bp0", 32'h5000_0000, 6'd1, 4'b0000, 1'b1, 1'b1);
    chk_rec("bp1", 32'h5000_0001, 6'd1, 4'b0000, 1'b1, 1'b1);
    chk_rec("bp2", 32'h5000_0002, 6'd1, 4'b0000, 1'b1, 1'b1);
    chk("bp_drained", 32'(res_valid), 32'd0);
    chk("bp_ready_back", 32'(noc_ready_out), 32'd1);
    exp_ok += 3;
    chk_cnts("bp");

    // SOP inside a frame closes the old frame with err[1]
    beat(32'h7000_0000, 1'b1, 1'b0);
    beat(32'h7000_0000, 1'b0, 1'b0);
    beat(32'h7000_0001, 1'b1, 1'b0);
    beat(32'h7000_0001, 1'b0, 1'b1);
    chk_rec("sopin_old", 32'h7000_0000, 6'd0, 4'b0010, 1'b1, 1'b0);
    chk_rec("sopin_new", 32'h7000_0001, 6'd2, 4'b0000, 1'b1, 1'b1);
    exp_err++;
    exp_ok++;
    chk_cnts("sopin");

    // ID change on a non-SOP beat
    beat(32'h8000_0000, 1'b1, 1'b0);
    beat(32'h8000_0009, 1'b0, 1'b1);
    chk_rec("idmis", 32'h8000_0000, 6'd2, 4'b0010, 1'b1, 1'b1);
    exp_err++;
    chk_cnts("idmis");

    // Reset mid-frame, then a clean frame
    beat(32'h6000_0000, 1'b1, 1'b0);
    beat(32'h6000_0000, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    exp_ok = 0;
    exp_err = 0;
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_ready", 32'(noc_ready_out), 32'd0);
    chk_cnts("midrst");
    @(negedge clk);
    rst = 1'b1;
    frame(32'h6000_0007, 2);
    chk_rec("postrst", 32'h6000_0007, 6'd2, 4'b0000, 1'b1, 1'b1);
    exp_ok++;
    chk_cnts("postrst");
    chk("postrst_empty", 32'(res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
